crossbar_switch_rr: RTL and testbench
=====================================

Name: crossbar_switch_rr

Overview:
Parametrised PORTS x PORTS crossbar for WIDTH-bit words. Each input carries its own destination index and uses a valid/ready handshake. Each output has a round-robin arbiter and a one-entry output register. This generalises the fixed 4x4/4-bit control-word crossbar into a flow-controlled switch with contention handling. It sits between producer lanes and consumer lanes in lab datapaths.

Parameters:
WIDTH, 4, data bits per port
PORTS, 4, number of input ports and of output ports (2..8)
DEST_W, $clog2(PORTS), width of each destination field (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  PORTS*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
in_dest  input  PORTS*DEST_W  destination output index for input i, bits [i*DEST_W +: DEST_W]
in_valid  input  PORTS  input i presents a word
in_ready  output  PORTS  input i's word is accepted this cycle (combinational)
dest_err  output  PORTS  in_valid[i] is high and in_dest[i] >= PORTS (combinational)
out_data  output  PORTS*WIDTH  registered data for output j
out_src  output  PORTS*DEST_W  index of the input that supplied out_data[j]
out_valid  output  PORTS  output j holds a word
out_ready  input  PORTS  consumer of output j accepts the word

Behaviour:
- Request: input i requests output j when in_valid[i] and in_dest[i] == j. A destination >= PORTS requests nothing, so in_ready[i] stays 0 and dest_err[i] is 1.
- Output j may load when load_ok[j] = !out_valid[j] || out_ready[j].
- Arbitration per output j:
  - Scan inputs ptr[j], ptr[j]+1, ... modulo PORTS; the first requester wins.
  - A grant is issued only if load_ok[j].
  - in_ready[i] = 1 exactly when input i is the granted winner of its destination.
  - At most one input is granted per output per cycle. An input can be granted by only one output.
- Transfer on the clock edge when output j grants input w:
  - out_data[j] <= in_data[w]
  - out_src[j] <= w
  - out_valid[j] <= 1
  - ptr[j] <= (w+1) mod PORTS
- No grant and out_ready[j] = 1: out_valid[j] <= 0; out_data and out_src hold their last values.
- No grant and out_ready[j] = 0: all state of output j holds.
- Latency is 1 cycle from the accepting edge to out_valid.
- Full throughput: a word drained (out_valid & out_ready) and a new word loaded can happen in the same cycle.
- Stability: while out_valid[j] && !out_ready[j], out_data[j] and out_src[j] must not change.
- ptr[j] changes only on a grant. Uncontended traffic still advances it.
- Inputs are independent: a stalled input never blocks other inputs targeting other outputs. There is no head-of-line coupling inside the block.
- in_ready depends combinationally on in_valid and in_dest. Producers must not make in_valid depend on in_ready.
- Reset (asynchronous, any time), applied immediately:
  - out_valid = 0, out_data = 0, out_src = 0, ptr[*] = 0.
  - Words held in output registers are discarded.
  - in_ready and dest_err are 0 while rst is high.
- Control is fully synchronous after reset deasserts. The first edge after deassertion may already grant.

Test Plan:
1. Reset check: assert rst mid-simulation with traffic present -> out_valid=0, out_data=0, out_src=0, in_ready=0 immediately, without waiting for a clock edge. After release, all ptr values are 0; verify via contention order in test 3.
2. Permutation, all out_ready=1: inputs 0..3 carry data 1,2,3,4 with dest 3,2,1,0 -> in_ready=4'b1111 in the same cycle. Next cycle: out_data3=1, out_data2=2, out_data1=3, out_data0=4, out_src={0,1,2,3} reversed accordingly, out_valid=4'b1111.
3. Contention: all inputs hold dest=0 with data A,B,C,D, out_ready[0]=1 -> grants 0,1,2,3 on consecutive cycles, out_data0 sequence A,B,C,D, one in_ready bit high per cycle. With input 0 re-presenting afterwards, the wrap back to input 0 occurs on the 5th cycle.
4. Backpressure: out_valid[1]=1, out_ready[1]=0, input 2 requesting dest 1 -> in_ready[2]=0 and out_data1 stable for 5 cycles. Raise out_ready[1] -> in_ready[2]=1 that cycle, and the new word appears next cycle with out_valid[1] still 1 (no bubble).
5. Independence: input 0 stalled on blocked output 2 while input 1 targets free output 3 -> input 1 accepted every cycle and out_valid[3]=1 from the second cycle.
6. PORTS=3, WIDTH=8: in_dest[0]=3 with in_valid[0]=1 -> dest_err[0]=1, in_ready[0]=0, no out_valid change. Inputs 1 and 2 route normally.

Source files
------------

// File: rtl/crossbar_switch_rr_if.sv
// Bus bundle for the round-robin crossbar: per-input requests with destination
// index and per-output registered words, both with valid/ready handshakes.
interface crossbar_switch_rr_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PORTS = 4
);
    localparam int unsigned DEST_W = $clog2(PORTS);

    logic [PORTS*WIDTH-1:0]  in_data;
    logic [PORTS*DEST_W-1:0] in_dest;
    logic [PORTS-1:0]        in_valid;
    logic [PORTS-1:0]        in_ready;
    logic [PORTS-1:0]        dest_err;
    logic [PORTS*WIDTH-1:0]  out_data;
    logic [PORTS*DEST_W-1:0] out_src;
    logic [PORTS-1:0]        out_valid;
    logic [PORTS-1:0]        out_ready;

    // Producer/consumer side: drives requests and output-side ready.
    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, dest_err, out_data, out_src, out_valid
    );

    // Switch side.
    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, dest_err, out_data, out_src, out_valid
    );
endinterface

// File: rtl/crossbar_switch_rr.sv
// PORTS x PORTS flow-controlled crossbar. Every output owns a round-robin
// arbiter and a one-entry output register; a word drained and a new word
// loaded may happen on the same edge.
module crossbar_switch_rr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PORTS = 4
) (
    input logic                 clk,
    input logic                 rst,
    crossbar_switch_rr_if.slave sw
);
    localparam int unsigned DEST_W = $clog2(PORTS);

    logic [PORTS-1:0][WIDTH-1:0]  out_data_q, out_data_d;
    logic [PORTS-1:0][DEST_W-1:0] out_src_q, out_src_d;
    logic [PORTS-1:0]             out_valid_q, out_valid_d;
    logic [PORTS-1:0][DEST_W-1:0] ptr_q, ptr_d;

    logic [PORTS-1:0][PORTS-1:0]  req;      // req[j][i]: input i wants output j
    logic [PORTS-1:0][PORTS-1:0]  gnt;      // gnt[j][i]: output j grants input i
    logic [PORTS-1:0]             gnt_any;
    logic [PORTS-1:0][DEST_W-1:0] win;
    logic [PORTS-1:0]             load_ok;
    logic [PORTS-1:0]             in_ready_raw;
    logic [PORTS-1:0]             dest_err_raw;

    // Decode each input's destination into a per-output request vector.
    always_comb begin
        req = '0;
        for (int j = 0; j < int'(PORTS); j++) begin
            for (int i = 0; i < int'(PORTS); i++) begin
                req[j][i] = sw.in_valid[i] &&
                            (32'(sw.in_dest[i*DEST_W +: DEST_W]) == 32'(j));
            end
        end
    end

    // Round-robin scan from ptr[j]; only grant when the output register can load.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = '0;
        win     = '0;
        load_ok = '0;
        for (int j = 0; j < int'(PORTS); j++) begin
            load_ok[j] = !out_valid_q[j] || sw.out_ready[j];
            for (int k = 0; k < int'(PORTS); k++) begin
                idx = (int'(ptr_q[j]) + k) % int'(PORTS);
                if (load_ok[j] && !gnt_any[j] && req[j][idx]) begin
                    gnt_any[j]  = 1'b1;
                    gnt[j][idx] = 1'b1;
                    win[j]      = DEST_W'(idx);
                end
            end
        end
    end

    // Collapse grants per input and flag unroutable destinations.
    always_comb begin
        in_ready_raw = '0;
        dest_err_raw = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            for (int j = 0; j < int'(PORTS); j++) begin
                in_ready_raw[i] = in_ready_raw[i] | gnt[j][i];
            end
            dest_err_raw[i] = sw.in_valid[i] &&
                              (32'(sw.in_dest[i*DEST_W +: DEST_W]) >= 32'(PORTS));
        end
    end

    // Output register next state: load on grant, drop valid on drain, else hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        for (int j = 0; j < int'(PORTS); j++) begin
            if (gnt_any[j]) begin
                out_data_d[j]  = sw.in_data[int'(win[j])*WIDTH +: WIDTH];
                out_src_d[j]   = win[j];
                out_valid_d[j] = 1'b1;
                ptr_d[j]       = DEST_W'((int'(win[j]) + 1) % int'(PORTS));
            end else if (sw.out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    // State registers; reset discards any held words and rewinds the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign sw.in_ready  = rst ? '0 : in_ready_raw;
    assign sw.dest_err  = rst ? '0 : dest_err_raw;
    assign sw.out_data  = out_data_q;
    assign sw.out_src   = out_src_q;
    assign sw.out_valid = out_valid_q;

endmodule

// File: tb/tb_crossbar_switch_rr.sv
// Directed bench for crossbar_switch_rr: a 4x4/4-bit instance for routing,
// contention, backpressure and reset, plus a 3-port/8-bit instance for
// out-of-range destinations.
module tb_crossbar_switch_rr;
    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    crossbar_switch_rr_if #(.WIDTH(4), .PORTS(4)) a ();
    crossbar_switch_rr_if #(.WIDTH(8), .PORTS(3)) b ();

    crossbar_switch_rr #(.WIDTH(4), .PORTS(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .sw  (a)
    );

    crossbar_switch_rr #(.WIDTH(8), .PORTS(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .sw  (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst     = 1'b1;

        // Permutation stimulus is already applied while in reset.
        a.in_data   = 16'h4321;
        a.in_dest   = 8'h1B;
        a.in_valid  = 4'hF;
        a.out_ready = 4'hF;
        b.in_data   = '0;
        b.in_dest   = '0;
        b.in_valid  = '0;
        b.out_ready = '1;
        #1;
        chk("rst_in_ready", 32'(a.in_ready), 32'h0);
        chk("rst_out_valid", 32'(a.out_valid), 32'h0);
        #11;
        rst = 1'b0;

        // Permutation with all outputs ready.
        #1;
        chk("perm_in_ready", 32'(a.in_ready), 32'hF);
        tick();
        chk("perm_out_data", 32'(a.out_data), 32'h1234);
        chk("perm_out_src", 32'(a.out_src), 32'h1B);
        chk("perm_out_valid", 32'(a.out_valid), 32'hF);

        // Input 1 alone to output 0 moves ptr[0] to 2.
        a.in_data  = 16'h0090;
        a.in_dest  = 8'h00;
        a.in_valid = 4'b0010;
        #1;
        chk("single_in_ready", 32'(a.in_ready), 32'h2);
        tick();
        chk("single_out_data", 32'(a.out_data), 32'h1239);
        chk("single_out_src", 32'(a.out_src), 32'h19);
        chk("single_out_valid", 32'(a.out_valid), 32'h1);

        // Contention on output 0 with ptr[0]=2 picks input 2 first.
        a.in_data  = 16'hDCBA;
        a.in_dest  = 8'h00;
        a.in_valid = 4'hF;
        #1;
        chk("ptr2_in_ready", 32'(a.in_ready), 32'h4);

        // Asynchronous reset between edges with traffic present.
        #1;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(a.out_valid), 32'h0);
        chk("async_out_data", 32'(a.out_data), 32'h0);
        chk("async_out_src", 32'(a.out_src), 32'h0);
        chk("async_in_ready", 32'(a.in_ready), 32'h0);
        #3;
        rst = 1'b0;

        // Contention after reset: grants 0,1,2,3 then wrap to 0.
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("cont_in_ready", 32'(a.in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("cont_out_data0", 32'(a.out_data[3:0]), 32'(4'hA + (k % 4)));
            chk("cont_out_src0", 32'(a.out_src[1:0]), 32'(k % 4));
        end

        // Backpressure on output 1.
        a.in_data  = 16'h0500;
        a.in_dest  = 8'h10;
        a.in_valid = 4'b0100;
        #1;
        chk("bp_load_in_ready", 32'(a.in_ready), 32'h4);
        tick();
        chk("bp_load_valid", 32'(a.out_valid), 32'h2);
        a.in_data   = 16'h0600;
        a.out_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_stall_in_ready", 32'(a.in_ready), 32'h0);
            tick();
            chk("bp_stall_data1", 32'(a.out_data[7:4]), 32'h5);
            chk("bp_stall_valid1", 32'(a.out_valid[1]), 32'h1);
        end
        a.out_ready = 4'hF;
        #1;
        chk("bp_release_in_ready", 32'(a.in_ready), 32'h4);
        tick();
        chk("bp_release_data1", 32'(a.out_data[7:4]), 32'h6);
        chk("bp_release_valid1", 32'(a.out_valid[1]), 32'h1);
        chk("bp_release_src1", 32'(a.out_src[3:2]), 32'h2);

        // Independence: fill output 2, then block it while input 1 streams to 3.
        a.in_data  = 16'h0007;
        a.in_dest  = 8'h02;
        a.in_valid = 4'b0001;
        #1;
        chk("ind_fill_in_ready", 32'(a.in_ready), 32'h1);
        tick();
        a.out_ready = 4'b1011;
        a.in_dest   = 8'h0E;
        a.in_valid  = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            a.in_data = 16'(((k + 1) << 4) | 8);
            #1;
            chk("ind_in_ready", 32'(a.in_ready), 32'h2);
            tick();
            chk("ind_valid3", 32'(a.out_valid[3]), 32'h1);
            chk("ind_data3", 32'(a.out_data[15:12]), 32'(k + 1));
            chk("ind_data2_stable", 32'(a.out_data[11:8]), 32'h7);
        end
        a.in_valid = '0;

        // Three-port instance: destination 3 is out of range.
        b.in_data  = 24'h332211;
        b.in_dest  = 6'h13;
        b.in_valid = 3'b111;
        #1;
        chk("p3_dest_err", 32'(b.dest_err), 32'h1);
        chk("p3_in_ready", 32'(b.in_ready), 32'h6);
        chk("p4_dest_err", 32'(a.dest_err), 32'h0);
        tick();
        chk("p3_out_valid", 32'(b.out_valid), 32'h3);
        chk("p3_out_data", 32'(b.out_data), 32'h003322);
        chk("p3_out_src", 32'(b.out_src), 32'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
